// File: rtl/sh2_pkg.sv
// Shared SH-2 bus types: access sizes, arbiter state encoding and byte-lane helpers.
package sh2_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_LONG = 2'b10
    } MemSize_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_IF_ACC    = 3'd1,
        ST_MA_ACC    = 3'd2,
        ST_LOCK_HOLD = 3'd3,
        ST_DMA_GNT   = 3'd4
    } ArbState_t;

    localparam int IF_STARVE_MAX_DEF = 4;

    function automatic logic [31:0] ByteShiftRigth(input logic [31:0] data, input logic [1:0] lanes);
        return data >> {lanes, 3'b000};
    endfunction

    // The reserved size code 2'b11 behaves as a longword access.
    function automatic MemSize_t norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_LONG : MemSize_t'(sz);
    endfunction

    function automatic logic [31:0] write_lanes(input MemSize_t sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_WORD: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Big-endian lane select: byte address 0 lives in DI[31:24].
    function automatic logic [31:0] read_lanes(input MemSize_t sz, input logic [1:0] a, input logic [31:0] di);
        logic [31:0] shifted;
        shifted = ByteShiftRigth(di, 2'd3 - a);
        case (sz)
            SZ_BYTE: return {24'h0, shifted[7:0]};
            SZ_WORD: return a[1] ? {16'h0, di[15:0]} : {16'h0, di[31:16]};
            default: return di;
        endcase
    endfunction

endpackage

// File: rtl/sh2_bus_arb.sv
// Arbiter for the SH-2 shared bus: instruction fetch, data access with locked
// read-modify-write, and external DMA bus hand-over.
module sh2_bus_arb
    import sh2_pkg::*;
#(
    parameter int IF_STARVE_MAX = IF_STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_data,
    input  logic        ma_req,
    input  logic [31:0] ma_addr,
    input  logic        ma_wr,
    input  logic [1:0]  ma_sz,
    input  logic [31:0] ma_wd,
    input  logic        ma_lock,
    output logic        ma_ack,
    output logic [31:0] ma_rd,
    input  logic        dreq,
    output logic        dack,
    output logic [31:0] bus_a,
    output logic [31:0] bus_do,
    input  logic [31:0] bus_di,
    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_sz,
    input  logic        bus_busy,
    output logic        bus_lock
);

    localparam int CW = $clog2(IF_STARVE_MAX + 1);

    ArbState_t   state_reg, state_next;
    logic [CW-1:0] starve_reg;
    logic        ready_reg;
    logic        lock_reg;
    logic        follow_reg;
    logic        lat_wr_reg;
    MemSize_t    lat_sz_reg;
    logic [31:0] bus_a_reg;
    logic [31:0] bus_do_reg;
    logic        if_ack_reg;
    logic        ma_ack_reg;
    logic [15:0] if_data_reg;
    logic [31:0] ma_rd_reg;

    logic grant_if, grant_ma, done_if, done_ma, starve_full;

    assign starve_full = (starve_reg == CW'(IF_STARVE_MAX));

    always_comb begin
        state_next = state_reg;
        grant_if   = 1'b0;
        grant_ma   = 1'b0;
        done_if    = 1'b0;
        done_ma    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // ready_reg delays the first grant by one CE edge after reset release.
                if (ready_reg) begin
                    if (dreq) begin
                        state_next = ST_DMA_GNT;
                    end else if (if_req && (!ma_req || starve_full)) begin
                        state_next = ST_IF_ACC;
                        grant_if   = 1'b1;
                    end else if (ma_req) begin
                        state_next = ST_MA_ACC;
                        grant_ma   = 1'b1;
                    end
                end
            end
            ST_IF_ACC: begin
                if (!bus_busy) begin
                    done_if    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_MA_ACC: begin
                if (!bus_busy) begin
                    done_ma    = 1'b1;
                    state_next = (lock_reg && !follow_reg) ? ST_LOCK_HOLD : ST_IDLE;
                end
            end
            ST_LOCK_HOLD: begin
                if (ma_req) begin
                    state_next = ST_MA_ACC;
                    grant_ma   = 1'b1;
                end
            end
            ST_DMA_GNT: begin
                if (!dreq) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            starve_reg  <= '0;
            ready_reg   <= 1'b0;
            lock_reg    <= 1'b0;
            follow_reg  <= 1'b0;
            lat_wr_reg  <= 1'b0;
            lat_sz_reg  <= SZ_BYTE;
            bus_a_reg   <= '0;
            bus_do_reg  <= '0;
            if_ack_reg  <= 1'b0;
            ma_ack_reg  <= 1'b0;
            if_data_reg <= '0;
            ma_rd_reg   <= '0;
        end else if (ce) begin
            state_reg  <= state_next;
            ready_reg  <= 1'b1;
            if_ack_reg <= 1'b0;
            ma_ack_reg <= 1'b0;
            if (grant_if) begin
                bus_a_reg  <= if_addr;
                lat_wr_reg <= 1'b0;
                lat_sz_reg <= SZ_WORD;
                bus_do_reg <= '0;
                starve_reg <= '0;
            end
            if (grant_ma) begin
                bus_a_reg  <= ma_addr;
                lat_wr_reg <= ma_wr;
                lat_sz_reg <= norm_size(ma_sz);
                bus_do_reg <= write_lanes(norm_size(ma_sz), ma_wd);
                if (state_reg == ST_LOCK_HOLD) follow_reg <= 1'b1;
                else                           lock_reg   <= ma_lock && !ma_wr;
                if (if_req && !starve_full) starve_reg <= starve_reg + 1'b1;
            end
            if (done_if) begin
                if_ack_reg  <= 1'b1;
                if_data_reg <= bus_a_reg[1] ? bus_di[15:0] : bus_di[31:16];
            end
            if (done_ma) begin
                ma_ack_reg <= 1'b1;
                if (!lat_wr_reg) ma_rd_reg <= read_lanes(lat_sz_reg, bus_a_reg[1:0], bus_di);
                // The access following a locked read releases the lock.
                if (follow_reg) begin
                    lock_reg   <= 1'b0;
                    follow_reg <= 1'b0;
                end
            end
        end
    end

    assign if_ack   = if_ack_reg;
    assign if_data  = if_data_reg;
    assign ma_ack   = ma_ack_reg;
    assign ma_rd    = ma_rd_reg;
    assign dack     = (state_reg == ST_DMA_GNT);
    assign bus_req  = (state_reg == ST_IF_ACC) || (state_reg == ST_MA_ACC);
    assign bus_we   = (state_reg == ST_MA_ACC) && lat_wr_reg;
    assign bus_a    = bus_a_reg;
    assign bus_do   = bus_do_reg;
    assign bus_sz   = lat_sz_reg;
    assign bus_lock = lock_reg;

endmodule

// File: tb/tb_sh2_bus_arb.sv
// Directed bench for sh2_bus_arb: reset, fetch, starvation rotation, lanes, TAS lock, DMA, abort.
module tb_sh2_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n, ce;
    logic        if_req, if_ack;
    logic [31:0] if_addr;
    logic [15:0] if_data;
    logic        ma_req, ma_wr, ma_lock, ma_ack;
    logic [31:0] ma_addr, ma_wd, ma_rd;
    logic [1:0]  ma_sz;
    logic        dreq, dack;
    logic [31:0] bus_a, bus_do, bus_di;
    logic        bus_req, bus_we, bus_busy, bus_lock;
    logic [1:0]  bus_sz;

    int vec_cnt = 0;
    int err_cnt = 0;

    sh2_bus_arb #(.IF_STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .ma_req(ma_req), .ma_addr(ma_addr), .ma_wr(ma_wr), .ma_sz(ma_sz),
        .ma_wd(ma_wd), .ma_lock(ma_lock), .ma_ack(ma_ack), .ma_rd(ma_rd),
        .dreq(dreq), .dack(dack),
        .bus_a(bus_a), .bus_do(bus_do), .bus_di(bus_di), .bus_req(bus_req),
        .bus_we(bus_we), .bus_sz(bus_sz), .bus_busy(bus_busy), .bus_lock(bus_lock)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[%0d] %s observed=%h expected=%h", vec_cnt, tag, obs, exp);
    endtask

    initial begin
        logic is_if;
        rst_n = 1'b1; ce = 1'b1;
        if_req = 0; if_addr = 32'h0; ma_req = 0; ma_addr = 32'h0; ma_wr = 0;
        ma_sz = 2'b10; ma_wd = 32'h0; ma_lock = 0; dreq = 0;
        bus_di = 32'h0; bus_busy = 0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_dack", 32'(dack), 0);
        check("rst_bus_lock", 32'(bus_lock), 0);
        check("rst_bus_a", bus_a, 0);
        check("rst_if_data", 32'(if_data), 0);
        check("rst_ma_rd", ma_rd, 0);
        step(); step();

        // first grant on second edge after release; basic fetch
        rst_n = 1'b1;
        if_req = 1; if_addr = 32'h0000_0102; bus_di = 32'h1234_5678;
        step();
        check("first_edge_no_grant", 32'(bus_req), 0);
        step();
        check("if_bus_req", 32'(bus_req), 1);
        check("if_bus_a", bus_a, 32'h0000_0102);
        check("if_bus_sz", 32'(bus_sz), 32'd1);
        check("if_bus_we", 32'(bus_we), 0);
        check("if_ack_early", 32'(if_ack), 0);
        step();
        check("if_ack", 32'(if_ack), 1);
        check("if_data", 32'(if_data), 32'h5678);
        if_req = 0;
        step();
        check("if_ack_pulse", 32'(if_ack), 0);
        check("if_idle_bus_req", 32'(bus_req), 0);

        // starvation rotation: MA,MA,MA,MA,IF repeating
        if_req = 1; ma_req = 1; ma_addr = 32'h0000_0200; ma_sz = 2'b10; ma_wr = 0;
        for (int i = 0; i < 10; i++) begin
            is_if = (i % 5 == 4);
            step();
            check($sformatf("rot_grant_%0d", i), bus_a, is_if ? 32'h0000_0102 : 32'h0000_0200);
            step();
            check($sformatf("rot_ack_%0d", i), {30'h0, if_ack, ma_ack}, is_if ? 32'd2 : 32'd1);
        end
        check("ma_long_rd", ma_rd, 32'h1234_5678);
        if_req = 0; ma_req = 0;
        step();

        // byte read with 3 wait cycles
        ma_req = 1; ma_addr = 32'h0000_0301; ma_sz = 2'b00; bus_di = 32'hAABB_CCDD; bus_busy = 1;
        step();
        check("byte_bus_sz", 32'(bus_sz), 0);
        step(); step(); step();
        check("byte_wait_no_ack", 32'(ma_ack), 0);
        bus_busy = 0;
        step();
        check("byte_ack", 32'(ma_ack), 1);
        check("byte_rd", ma_rd, 32'h0000_00BB);
        ma_req = 0;
        step();

        // write lane replication
        ma_req = 1; ma_wr = 1; ma_addr = 32'h0000_0400; ma_sz = 2'b01; ma_wd = 32'h1111_ABCD;
        step();
        check("word_wr_we", 32'(bus_we), 1);
        check("word_wr_do", bus_do, 32'hABCD_ABCD);
        step();
        ma_sz = 2'b00; ma_wd = 32'h1234_56EF;
        step();
        check("byte_wr_do", bus_do, 32'hEFEF_EFEF);
        step();
        ma_sz = 2'b11; ma_wd = 32'hCAFE_F00D;
        step();
        check("sz11_bus_sz", 32'(bus_sz), 32'd2);
        check("sz11_do", bus_do, 32'hCAFE_F00D);
        step();
        check("sz11_ack", 32'(ma_ack), 1);
        ma_req = 0; ma_wr = 0;
        step();

        // TAS: locked read, then write; DMA and IF locked out
        ma_req = 1; ma_lock = 1; ma_sz = 2'b00; ma_addr = 32'h0000_0500; bus_di = 32'h0000_0000;
        step();
        check("tas_lock_grant", 32'(bus_lock), 1);
        dreq = 1; if_req = 1;
        step();
        check("tas_rd_ack", 32'(ma_ack), 1);
        check("tas_lock_hold", 32'(bus_lock), 1);
        ma_req = 0;
        step();
        check("tas_hold_dack", 32'(dack), 0);
        check("tas_hold_bus_req", 32'(bus_req), 0);
        ma_req = 1; ma_wr = 1; ma_lock = 0; ma_wd = 32'h0000_0080;
        step();
        check("tas_wr_grant", {29'h0, bus_we, dack, bus_lock}, 32'h5);
        step();
        check("tas_wr_ack", {29'h0, ma_ack, if_ack, bus_lock}, 32'h4);
        ma_req = 0; ma_wr = 0;
        step();
        check("tas_then_dack", {29'h0, dack, bus_req, bus_lock}, 32'h4);
        dreq = 0; if_req = 0;
        step();
        check("tas_dack_release", 32'(dack), 0);
        step();

        // DMA requested during an MA access
        ma_req = 1; ma_sz = 2'b10; bus_busy = 1; bus_di = 32'h0BAD_BEEF;
        step();
        dreq = 1;
        step();
        bus_busy = 0;
        step();
        check("dma_ma_ack", {30'h0, ma_ack, dack}, 32'h2);
        ma_req = 0;
        step();
        check("dma_gnt", {30'h0, dack, bus_req}, 32'h2);
        step();
        check("dma_hold", {30'h0, dack, bus_req}, 32'h2);
        dreq = 0;
        step();
        check("dma_drop", 32'(dack), 0);

        // reset mid-access aborts without ack
        ma_req = 1; bus_busy = 1; ma_addr = 32'h0000_0600;
        step();
        check("abort_pre", 32'(bus_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {28'h0, bus_req, ma_ack, bus_lock, dack}, 0);
        check("abort_bus_a", bus_a, 0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_no_early_grant", {30'h0, bus_req, ma_ack}, 0);
        step();
        check("abort_regrant", bus_a, 32'h0000_0600);
        bus_busy = 0;
        step();
        check("abort_reissue_ack", 32'(ma_ack), 1);
        ma_req = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sh2_bus_arb.md
SH2_BUS_ARB -- requirements
Module: sh2_bus_arb

Interface
REQ-001 Parameter IF_STARVE_MAX, default 4: consecutive MA grants allowed while IF is pending before IF is forced.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 CE  in  1  clock enable; FSM, counter and register updates occur only on CLK edges with CE=1.
REQ-005 IF_REQ in 1, IF_ADDR in 32, IF_ACK out 1, IF_DATA out 16: instruction fetch port (read-only, word).
REQ-006 MA_REQ in 1, MA_ADDR in 32, MA_WR in 1, MA_SZ in 2 (MemSize_t), MA_WD in 32, MA_LOCK in 1, MA_ACK out 1, MA_RD out 32: data access port.
REQ-007 DREQ in 1, DACK out 1: external master (DMA) bus request/grant.
REQ-008 BUS_A out 32, BUS_DO out 32, BUS_DI in 32, BUS_REQ out 1, BUS_WE out 1, BUS_SZ out 2, BUS_BUSY in 1 (wait), BUS_LOCK out 1: shared bus.

Function
REQ-009 FSM states: IDLE, IF_ACC, MA_ACC, LOCK_HOLD, DMA_GNT.
REQ-010 IDLE winner priority: DMA > MA > IF; if IF pending and starve counter = IF_STARVE_MAX, IF wins over MA (DMA still first).
REQ-011 On grant, address, WR, SZ, WD and LOCK are latched; requester changes during the access are ignored.
REQ-012 In IF_ACC/MA_ACC: BUS_REQ=1, BUS_A/BUS_WE/BUS_SZ/BUS_DO from latched values; IF accesses drive BUS_WE=0, BUS_SZ=WORD.
REQ-013 Access completes on first CE edge with BUS_BUSY=0; ACK of that port pulses high exactly one CE cycle, read data valid in the same cycle (registered).
REQ-014 Minimum latency: REQ sampled in IDLE -> access state next CE -> ACK following CE with zero wait; each BUS_BUSY=1 cycle adds one.
REQ-015 After completion FSM returns to IDLE, except REQ-017; requesters hold REQ until ACK and may drop it in the ACK cycle.
REQ-016 Starve counter: increments on each MA grant while IF_REQ=1, saturates at IF_STARVE_MAX, clears on any IF grant.
REQ-017 MA read with latched LOCK=1: on completion go to LOCK_HOLD, BUS_LOCK stays 1; only MA granted from LOCK_HOLD (DMA and IF blocked, starve rule suspended).
REQ-018 BUS_LOCK=1 from grant of locked read through completion of next MA access; cleared at that completion, FSM to IDLE.
REQ-019 DMA_GNT: DACK=1, BUS_REQ=0, BUS_LOCK=0; held while DREQ=1; DREQ=0 -> DACK=0 and IDLE next CE.
REQ-020 Write lanes: BYTE replicates MA_WD[7:0] to all 4 lanes, WORD replicates MA_WD[15:0] twice, LONG passes through.
REQ-021 Read lanes (big-endian): BYTE returns byte lane (3-A[1:0]) zero-extended; WORD returns A[1]?DI[15:0]:DI[31:16] zero-extended; LONG returns DI.
REQ-022 IF_DATA = IF_ADDR latched [1] ? BUS_DI[15:0] : BUS_DI[31:16].
REQ-023 MA_SZ=2'b11 treated as LONG.

Reset
REQ-024 RST_N=0 asynchronously forces IDLE, starve counter 0, lock cleared, and all outputs 0 (IF_ACK, MA_ACK, DACK, BUS_REQ, BUS_WE, BUS_LOCK, BUS_A, BUS_DO, BUS_SZ, IF_DATA, MA_RD).
REQ-025 Reset mid-access or mid-lock aborts without ACK; requesters reissue after release.
REQ-026 First grant possible on the second CE edge after RST_N rises.

Structure
REQ-027 ArbState_t enum and IF_STARVE_MAX default belong in SH2_PKG; MemSize_t and ByteShiftRigth reused from it.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 IF_REQ only, IF_ADDR=0x0000_0102, BUS_DI=0x1234_5678, BUS_BUSY=0 -> IF_ACK 2 CE after request, IF_DATA=0x5678.
REQ-030 MA and IF requesting every cycle, IF_STARVE_MAX=4 -> grant sequence MA,MA,MA,MA,IF repeating.
REQ-031 MA BYTE read A=0x...01, BUS_DI=0xAABBCCDD, 3 BUSY cycles -> MA_ACK after 5 CE, MA_RD=0x0000_00BB.
REQ-032 TAS: locked MA read, DREQ=1 and IF_REQ=1 raised -> BUS_LOCK stays 1, no DACK/IF_ACK until MA write completes, then DACK next.
REQ-033 DREQ asserted during MA access -> MA completes, then DACK=1 until DREQ=0; BUS_REQ=0 throughout grant.
REQ-034 RST_N pulsed low during MA_ACC with BUS_BUSY=1 -> outputs 0 immediately, no MA_ACK, IDLE after release.
